aes_key_expand_gen: RTL and testbench
=====================================

Name: aes_key_expand_gen

Overview:
Parametrised AES key-schedule engine supporting AES-128/192/256, selected at run time.
- Expands a cipher key into the full round-key word array, one 32-bit word per clock, under a start/busy/done handshake.
- Feeds the cipher datapath through a random-access round-key read port.
- Rcon is generated internally by GF(2^8) doubling; no memory-file initialisation is needed.

Parameters:
ALLOW_192, 1, 1 = AES-192 mode accepted; 0 = AES-192 request rejected with err
ALLOW_256, 1, 1 = AES-256 mode accepted; 0 = AES-256 request rejected with err
OUT_REG, 0, 0 = rk_out combinational from rk_idx; 1 = rk_out registered (+1 cycle read latency)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-high reset
start  in  1  request expansion; sampled only when busy=0
key_len  in  2  00=128, 01=192, 10=256, 11=reserved
key_in  in  256  cipher key, MSB-first, left-aligned; unused low bits ignored (128: [255:128]; 192: [255:64])
busy  out  1  expansion in progress
done  out  1  one-cycle pulse when the last word is written
key_valid  out  1  full schedule available; held until next accepted start or reset
err  out  1  one-cycle pulse on a rejected start
nr  out  4  round count of the stored schedule: 10/12/14
rk_idx  in  4  round-key index 0..14
rk_out  out  128  round key rk_idx = {w[4r], w[4r+1], w[4r+2], w[4r+3]}

Behaviour:
- Reset (async, any state): FSM->IDLE. busy=0, done=0, err=0, key_valid=0, nr=0, rk_out=0. Word store is cleared to 0. An expansion in progress is abandoned.
- Nk = 4/6/8; Nr = Nk+6; total words T = 4(Nr+1) = 44/52/60. The store holds 60 words of 32 bits.
- FSM states:
  - IDLE/DONE (busy=0): start with a legal key_len -> LOAD. key_valid clears that same edge. key_len is latched.
  - Start with key_len=11, or a mode disabled by parameter -> err pulses next cycle. State, key_valid and store are unchanged.
  - LOAD (1 cycle): w[0..Nk-1] <- key words. Set i=Nk, phase=0, rcon=0x01 -> EXPAND.
  - EXPAND (T-Nk cycles), one word per cycle, with t=w[i-1] and phase = i mod Nk kept as a counter (no divider):
    - phase==0: t = SubWord(RotWord(t)) ^ {rcon,24'h0}; then rcon <- xtime(rcon) (0x80 -> 0x1b).
    - Nk==8 and phase==4: t = SubWord(t).
    - w[i] = w[i-Nk] ^ t.
    - Leaving EXPAND after writing w[T-1]: done=1 for 1 cycle, key_valid=1, nr=Nr -> DONE.
- Latency from the start-accept edge to the done pulse: 128 -> 41 cycles, 192 -> 47 cycles, 256 -> 53 cycles. The next start may be accepted in the cycle after done.
- busy=1 in LOAD and EXPAND. start while busy is ignored, with no err.
- Read port: rk_out = 0 when key_valid=0 or rk_idx>nr. With OUT_REG=1 the value appears one cycle after rk_idx is presented.
- Width rules: all byte ops are 8-bit with no carries. Word byte 0 = bits [31:24]. RotWord moves byte 0 to byte 3.
- key_in and key_len changes after the start-accept edge have no effect.

Decomposition:
Package aes_pkg holds:
- key-length encodings;
- Nk/Nr/T lookup constants;
- xtime function;
- word/round-key typedefs.

Sub-module aes_sbox is a combinational 8-bit S-box implemented as a case table. The engine instantiates 4 of them, shared between the RotWord and AES-256 SubWord paths.

Test Plan:
1. 128-bit, key 2b7e151628aed2a6abf7158809cf4f3c -> done at +41 cycles. rk_idx=10 gives d014f9a8c9ee2589e13f0cc8b6630ca6. rk_idx=0 gives the key itself. rk_idx=11 gives 0. nr=10.
2. 192-bit, key 8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b -> done at +47 cycles. rk_idx=12 gives e98ba06f448c773c8ecc720401002202. nr=12.
3. 256-bit, key 603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4 -> done at +53 cycles. rk_idx=14 gives fe4890d1e6188d0b046df344706c631e. rk_idx=1 gives 1f352c073b6108d72d9810a30914dff4.
4. key_len=11, and separately ALLOW_256=0 with key_len=10 -> err pulse only. Prior key_valid and rk_out are unchanged. busy stays 0.
5. Assert rst at cycle 20 of a 256-bit expansion -> immediately busy=0, key_valid=0, rk_out=0. A restart with the vector from test 1 still matches test 1.
6. start re-pulsed during busy -> ignored and latency unchanged. Back-to-back 128 then 256 runs -> each result correct. key_valid is low between the two runs.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared AES key-schedule types, key-length encodings and lookup helpers.
package aes_pkg;

  typedef logic [31:0]  word_t;
  typedef logic [127:0] rkey_t;

  typedef enum logic [1:0] {
    KeyLen128  = 2'b00,
    KeyLen192  = 2'b01,
    KeyLen256  = 2'b10,
    KeyLenRsvd = 2'b11
  } key_len_e;

  typedef enum logic [1:0] {
    StIdle,
    StLoad,
    StExpand,
    StDone
  } state_e;

  localparam int unsigned NumWords = 60;

  localparam logic [3:0] Nk128 = 4'd4;
  localparam logic [3:0] Nk192 = 4'd6;
  localparam logic [3:0] Nk256 = 4'd8;

  function automatic logic [3:0] nk_of(key_len_e len);
    case (len)
      KeyLen192: return Nk192;
      KeyLen256: return Nk256;
      default:   return Nk128;
    endcase
  endfunction

  function automatic logic [3:0] nr_of(key_len_e len);
    return nk_of(len) + 4'd6;
  endfunction

  // Total schedule words: 4 * (Nr + 1).
  function automatic logic [5:0] words_of(key_len_e len);
    return {nr_of(len), 2'b00} + 6'd4;
  endfunction

  function automatic logic [7:0] xtime(logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

endpackage

// File: rtl/aes_sbox.sv
// Combinational AES forward S-box as a constant case table.
module aes_sbox (
  input  logic [7:0] a,
  output logic [7:0] y
);

  always_comb begin
    y = 8'h00;
    case (a)
      8'h00: y = 8'h63; 8'h01: y = 8'h7c; 8'h02: y = 8'h77; 8'h03: y = 8'h7b;
      8'h04: y = 8'hf2; 8'h05: y = 8'h6b; 8'h06: y = 8'h6f; 8'h07: y = 8'hc5;
      8'h08: y = 8'h30; 8'h09: y = 8'h01; 8'h0a: y = 8'h67; 8'h0b: y = 8'h2b;
      8'h0c: y = 8'hfe; 8'h0d: y = 8'hd7; 8'h0e: y = 8'hab; 8'h0f: y = 8'h76;
      8'h10: y = 8'hca; 8'h11: y = 8'h82; 8'h12: y = 8'hc9; 8'h13: y = 8'h7d;
      8'h14: y = 8'hfa; 8'h15: y = 8'h59; 8'h16: y = 8'h47; 8'h17: y = 8'hf0;
      8'h18: y = 8'had; 8'h19: y = 8'hd4; 8'h1a: y = 8'ha2; 8'h1b: y = 8'haf;
      8'h1c: y = 8'h9c; 8'h1d: y = 8'ha4; 8'h1e: y = 8'h72; 8'h1f: y = 8'hc0;
      8'h20: y = 8'hb7; 8'h21: y = 8'hfd; 8'h22: y = 8'h93; 8'h23: y = 8'h26;
      8'h24: y = 8'h36; 8'h25: y = 8'h3f; 8'h26: y = 8'hf7; 8'h27: y = 8'hcc;
      8'h28: y = 8'h34; 8'h29: y = 8'ha5; 8'h2a: y = 8'he5; 8'h2b: y = 8'hf1;
      8'h2c: y = 8'h71; 8'h2d: y = 8'hd8; 8'h2e: y = 8'h31; 8'h2f: y = 8'h15;
      8'h30: y = 8'h04; 8'h31: y = 8'hc7; 8'h32: y = 8'h23; 8'h33: y = 8'hc3;
      8'h34: y = 8'h18; 8'h35: y = 8'h96; 8'h36: y = 8'h05; 8'h37: y = 8'h9a;
      8'h38: y = 8'h07; 8'h39: y = 8'h12; 8'h3a: y = 8'h80; 8'h3b: y = 8'he2;
      8'h3c: y = 8'heb; 8'h3d: y = 8'h27; 8'h3e: y = 8'hb2; 8'h3f: y = 8'h75;
      8'h40: y = 8'h09; 8'h41: y = 8'h83; 8'h42: y = 8'h2c; 8'h43: y = 8'h1a;
      8'h44: y = 8'h1b; 8'h45: y = 8'h6e; 8'h46: y = 8'h5a; 8'h47: y = 8'ha0;
      8'h48: y = 8'h52; 8'h49: y = 8'h3b; 8'h4a: y = 8'hd6; 8'h4b: y = 8'hb3;
      8'h4c: y = 8'h29; 8'h4d: y = 8'he3; 8'h4e: y = 8'h2f; 8'h4f: y = 8'h84;
      8'h50: y = 8'h53; 8'h51: y = 8'hd1; 8'h52: y = 8'h00; 8'h53: y = 8'hed;
      8'h54: y = 8'h20; 8'h55: y = 8'hfc; 8'h56: y = 8'hb1; 8'h57: y = 8'h5b;
      8'h58: y = 8'h6a; 8'h59: y = 8'hcb; 8'h5a: y = 8'hbe; 8'h5b: y = 8'h39;
      8'h5c: y = 8'h4a; 8'h5d: y = 8'h4c; 8'h5e: y = 8'h58; 8'h5f: y = 8'hcf;
      8'h60: y = 8'hd0; 8'h61: y = 8'hef; 8'h62: y = 8'haa; 8'h63: y = 8'hfb;
      8'h64: y = 8'h43; 8'h65: y = 8'h4d; 8'h66: y = 8'h33; 8'h67: y = 8'h85;
      8'h68: y = 8'h45; 8'h69: y = 8'hf9; 8'h6a: y = 8'h02; 8'h6b: y = 8'h7f;
      8'h6c: y = 8'h50; 8'h6d: y = 8'h3c; 8'h6e: y = 8'h9f; 8'h6f: y = 8'ha8;
      8'h70: y = 8'h51; 8'h71: y = 8'ha3; 8'h72: y = 8'h40; 8'h73: y = 8'h8f;
      8'h74: y = 8'h92; 8'h75: y = 8'h9d; 8'h76: y = 8'h38; 8'h77: y = 8'hf5;
      8'h78: y = 8'hbc; 8'h79: y = 8'hb6; 8'h7a: y = 8'hda; 8'h7b: y = 8'h21;
      8'h7c: y = 8'h10; 8'h7d: y = 8'hff; 8'h7e: y = 8'hf3; 8'h7f: y = 8'hd2;
      8'h80: y = 8'hcd; 8'h81: y = 8'h0c; 8'h82: y = 8'h13; 8'h83: y = 8'hec;
      8'h84: y = 8'h5f; 8'h85: y = 8'h97; 8'h86: y = 8'h44; 8'h87: y = 8'h17;
      8'h88: y = 8'hc4; 8'h89: y = 8'ha7; 8'h8a: y = 8'h7e; 8'h8b: y = 8'h3d;
      8'h8c: y = 8'h64; 8'h8d: y = 8'h5d; 8'h8e: y = 8'h19; 8'h8f: y = 8'h73;
      8'h90: y = 8'h60; 8'h91: y = 8'h81; 8'h92: y = 8'h4f; 8'h93: y = 8'hdc;
      8'h94: y = 8'h22; 8'h95: y = 8'h2a; 8'h96: y = 8'h90; 8'h97: y = 8'h88;
      8'h98: y = 8'h46; 8'h99: y = 8'hee; 8'h9a: y = 8'hb8; 8'h9b: y = 8'h14;
      8'h9c: y = 8'hde; 8'h9d: y = 8'h5e; 8'h9e: y = 8'h0b; 8'h9f: y = 8'hdb;
      8'ha0: y = 8'he0; 8'ha1: y = 8'h32; 8'ha2: y = 8'h3a; 8'ha3: y = 8'h0a;
      8'ha4: y = 8'h49; 8'ha5: y = 8'h06; 8'ha6: y = 8'h24; 8'ha7: y = 8'h5c;
      8'ha8: y = 8'hc2; 8'ha9: y = 8'hd3; 8'haa: y = 8'hac; 8'hab: y = 8'h62;
      8'hac: y = 8'h91; 8'had: y = 8'h95; 8'hae: y = 8'he4; 8'haf: y = 8'h79;
      8'hb0: y = 8'he7; 8'hb1: y = 8'hc8; 8'hb2: y = 8'h37; 8'hb3: y = 8'h6d;
      8'hb4: y = 8'h8d; 8'hb5: y = 8'hd5; 8'hb6: y = 8'h4e; 8'hb7: y = 8'ha9;
      8'hb8: y = 8'h6c; 8'hb9: y = 8'h56; 8'hba: y = 8'hf4; 8'hbb: y = 8'hea;
      8'hbc: y = 8'h65; 8'hbd: y = 8'h7a; 8'hbe: y = 8'hae; 8'hbf: y = 8'h08;
      8'hc0: y = 8'hba; 8'hc1: y = 8'h78; 8'hc2: y = 8'h25; 8'hc3: y = 8'h2e;
      8'hc4: y = 8'h1c; 8'hc5: y = 8'ha6; 8'hc6: y = 8'hb4; 8'hc7: y = 8'hc6;
      8'hc8: y = 8'he8; 8'hc9: y = 8'hdd; 8'hca: y = 8'h74; 8'hcb: y = 8'h1f;
      8'hcc: y = 8'h4b; 8'hcd: y = 8'hbd; 8'hce: y = 8'h8b; 8'hcf: y = 8'h8a;
      8'hd0: y = 8'h70; 8'hd1: y = 8'h3e; 8'hd2: y = 8'hb5; 8'hd3: y = 8'h66;
      8'hd4: y = 8'h48; 8'hd5: y = 8'h03; 8'hd6: y = 8'hf6; 8'hd7: y = 8'h0e;
      8'hd8: y = 8'h61; 8'hd9: y = 8'h35; 8'hda: y = 8'h57; 8'hdb: y = 8'hb9;
      8'hdc: y = 8'h86; 8'hdd: y = 8'hc1; 8'hde: y = 8'h1d; 8'hdf: y = 8'h9e;
      8'he0: y = 8'he1; 8'he1: y = 8'hf8; 8'he2: y = 8'h98; 8'he3: y = 8'h11;
      8'he4: y = 8'h69; 8'he5: y = 8'hd9; 8'he6: y = 8'h8e; 8'he7: y = 8'h94;
      8'he8: y = 8'h9b; 8'he9: y = 8'h1e; 8'hea: y = 8'h87; 8'heb: y = 8'he9;
      8'hec: y = 8'hce; 8'hed: y = 8'h55; 8'hee: y = 8'h28; 8'hef: y = 8'hdf;
      8'hf0: y = 8'h8c; 8'hf1: y = 8'ha1; 8'hf2: y = 8'h89; 8'hf3: y = 8'h0d;
      8'hf4: y = 8'hbf; 8'hf5: y = 8'he6; 8'hf6: y = 8'h42; 8'hf7: y = 8'h68;
      8'hf8: y = 8'h41; 8'hf9: y = 8'h99; 8'hfa: y = 8'h2d; 8'hfb: y = 8'h0f;
      8'hfc: y = 8'hb0; 8'hfd: y = 8'h54; 8'hfe: y = 8'hbb; 8'hff: y = 8'h16;
    endcase
  end

endmodule

// File: rtl/aes_key_expand_gen.sv
// AES-128/192/256 key-schedule engine: one word per clock into a 60-word store,
// with a random-access round-key read port.
module aes_key_expand_gen
  import aes_pkg::*;
#(
  parameter bit ALLOW_192 = 1'b1,
  parameter bit ALLOW_256 = 1'b1,
  parameter bit OUT_REG   = 1'b0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [1:0]   key_len,
  input  logic [255:0] key_in,
  output logic         busy,
  output logic         done,
  output logic         key_valid,
  output logic         err,
  output logic [3:0]   nr,
  input  logic [3:0]   rk_idx,
  output logic [127:0] rk_out
);

  state_e         state_q;
  key_len_e       len_q;
  logic [255:0]   key_q;
  logic [5:0]     i_q;
  logic [2:0]     phase_q;
  logic [7:0]     rcon_q;
  word_t          w_q [NumWords];

  logic [5:0]     nk_w;
  logic [5:0]     total_w;
  logic           len_ok;
  word_t          w_prev;
  word_t          w_back;
  word_t          sub_in;
  word_t          sub_out;
  word_t          t_word;
  word_t          w_new;
  logic [5:0]     rk_base;
  rkey_t          rk_sel;

  assign nk_w    = {2'b00, nk_of(len_q)};
  assign total_w = words_of(len_q);

  always_comb begin
    len_ok = 1'b0;
    case (key_len_e'(key_len))
      KeyLen128: len_ok = 1'b1;
      KeyLen192: len_ok = ALLOW_192;
      KeyLen256: len_ok = ALLOW_256;
      default:   len_ok = 1'b0;
    endcase
  end

  assign w_prev = w_q[i_q - 6'd1];
  assign w_back = w_q[i_q - nk_w];

  // The four S-boxes serve both RotWord+SubWord and the AES-256 mid-block SubWord.
  assign sub_in = (phase_q == 3'd0) ? {w_prev[23:0], w_prev[31:24]} : w_prev;

  for (genvar b = 0; b < 4; b++) begin : g_sbox
    aes_sbox u_sbox (
      .a (sub_in[8*b +: 8]),
      .y (sub_out[8*b +: 8])
    );
  end

  always_comb begin
    t_word = w_prev;
    if (phase_q == 3'd0) begin
      t_word = sub_out ^ {rcon_q, 24'h000000};
    end else if (len_q == KeyLen256 && phase_q == 3'd4) begin
      t_word = sub_out;
    end
  end

  assign w_new = w_back ^ t_word;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      len_q     <= KeyLen128;
      key_q     <= '0;
      i_q       <= '0;
      phase_q   <= '0;
      rcon_q    <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      key_valid <= 1'b0;
      nr        <= '0;
      for (int k = 0; k < NumWords; k++) begin
        w_q[k] <= '0;
      end
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      unique case (state_q)
        StIdle, StDone: begin
          if (start) begin
            if (len_ok) begin
              len_q     <= key_len_e'(key_len);
              key_q     <= key_in;
              key_valid <= 1'b0;
              busy      <= 1'b1;
              state_q   <= StLoad;
            end else begin
              err <= 1'b1;
            end
          end
        end
        StLoad: begin
          for (int k = 0; k < 8; k++) begin
            if (k < int'(nk_of(len_q))) w_q[k] <= key_q[255 - 32*k -: 32];
          end
          i_q     <= nk_w;
          phase_q <= 3'd0;
          rcon_q  <= 8'h01;
          state_q <= StExpand;
        end
        StExpand: begin
          w_q[i_q] <= w_new;
          if (phase_q == 3'd0) rcon_q <= xtime(rcon_q);
          phase_q <= (phase_q == 3'(nk_w - 6'd1)) ? 3'd0 : phase_q + 3'd1;
          i_q     <= i_q + 6'd1;
          if (i_q == total_w - 6'd1) begin
            done      <= 1'b1;
            key_valid <= 1'b1;
            nr        <= nr_of(len_q);
            busy      <= 1'b0;
            state_q   <= StDone;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign rk_base = {rk_idx, 2'b00};

  always_comb begin
    rk_sel = '0;
    if (key_valid && rk_idx <= nr) begin
      rk_sel = {w_q[rk_base], w_q[rk_base + 6'd1], w_q[rk_base + 6'd2], w_q[rk_base + 6'd3]};
    end
  end

  if (OUT_REG) begin : g_out_reg
    rkey_t rk_q;
    always_ff @(posedge clk or posedge rst) begin
      if (rst) rk_q <= '0;
      else     rk_q <= rk_sel;
    end
    assign rk_out = rk_q;
  end else begin : g_out_comb
    assign rk_out = rk_sel;
  end

endmodule

// File: tb/tb_aes_key_expand_gen.sv
// Bench for aes_key_expand_gen: FIPS-197 style reference model checked every cycle,
// plus directed vectors from the published key-expansion examples.
module tb_aes_key_expand_gen;

  localparam logic [255:0] K128 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
  localparam logic [255:0] K192 = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0};
  localparam logic [255:0] K256 =
    256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
  localparam logic [127:0] R128_10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] R192_12 = 128'he98ba06f448c773c8ecc720401002202;
  localparam logic [127:0] R256_14 = 128'hfe4890d1e6188d0b046df344706c631e;

  logic         clk = 1'b0;
  logic         rst;
  logic         start, start1;
  logic [1:0]   key_len, key_len1;
  logic [255:0] key_in;
  logic [3:0]   rk_idx, rk_idx1;
  logic         busy, done, key_valid, err;
  logic         busy1, done1, key_valid1, err1;
  logic [3:0]   nr, nr1;
  logic [127:0] rk_out, rk_out1;

  logic         hold;
  logic [3:0]   hold_idx, sweep;
  int           n_cmp = 0;
  int           n_bad = 0;
  logic [7:0]   sb [256];

  always #5 clk = ~clk;
  assign rk_idx = hold ? hold_idx : sweep;

  aes_key_expand_gen u_dut (
    .clk(clk), .rst(rst), .start(start), .key_len(key_len), .key_in(key_in),
    .busy(busy), .done(done), .key_valid(key_valid), .err(err), .nr(nr),
    .rk_idx(rk_idx), .rk_out(rk_out)
  );

  aes_key_expand_gen #(.ALLOW_192(1'b1), .ALLOW_256(1'b0), .OUT_REG(1'b1)) u_dut1 (
    .clk(clk), .rst(rst), .start(start1), .key_len(key_len1), .key_in(key_in),
    .busy(busy1), .done(done1), .key_valid(key_valid1), .err(err1), .nr(nr1),
    .rk_idx(rk_idx1), .rk_out(rk_out1)
  );

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---- reference model: GF(2^8) arithmetic and textbook key expansion ----
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int k = 0; k < 8; k++) begin
      if (b[k]) p = p ^ x;
      x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1b) : {x[6:0], 1'b0};
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
    logic [15:0] d;
    d = {v, v} << n;
    return d[15:8];
  endfunction

  function automatic logic [7:0] sbox_math(input logic [7:0] a);
    logic [7:0] inv;
    inv = 8'h00;
    for (int y = 1; y < 256; y++) begin
      if (gf_mul(a, 8'(y)) == 8'h01) inv = 8'(y);
    end
    return inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
  endfunction

  function automatic logic [31:0] subw(input logic [31:0] t);
    return {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]};
  endfunction

  function automatic logic [127:0] mround(input logic [255:0] key, input logic [1:0] len,
                                          input logic [3:0] r);
    logic [31:0] w [64];
    logic [31:0] t;
    logic [7:0]  rc;
    int          nk, last;
    nk   = (len == 2'd0) ? 4 : (len == 2'd1) ? 6 : 8;
    last = 4 * int'(r) + 3;
    rc   = 8'h01;
    for (int i = 0; i <= last; i++) begin
      if (i < nk) begin
        w[i] = key[255 - 32*i -: 32];
      end else begin
        t = w[i-1];
        if (i % nk == 0) begin
          t  = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
          rc = gf_mul(rc, 8'h02);
        end else if (nk == 8 && i % nk == 4) begin
          t = subw(t);
        end
        w[i] = w[i-nk] ^ t;
      end
    end
    return {w[last-3], w[last-2], w[last-1], w[last]};
  endfunction

  // Cycle-level behaviour: accept, fixed latency, then publish the schedule.
  logic         m_busy, m_done, m_err, m_kv;
  logic [3:0]   m_nr;
  int           m_cnt;
  logic [255:0] m_key_p, m_key;
  logic [1:0]   m_len_p, m_len;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_busy <= 1'b0; m_done <= 1'b0; m_err <= 1'b0; m_kv <= 1'b0; m_nr <= 4'd0;
      m_cnt <= 0; m_key_p <= '0; m_key <= '0; m_len_p <= 2'd0; m_len <= 2'd0;
    end else begin
      m_done <= 1'b0;
      m_err  <= 1'b0;
      if (!m_busy) begin
        if (start && key_len == 2'b11) begin
          m_err <= 1'b1;
        end else if (start) begin
          m_busy  <= 1'b1;
          m_kv    <= 1'b0;
          m_key_p <= key_in;
          m_len_p <= key_len;
          m_cnt   <= (key_len == 2'd0) ? 41 : (key_len == 2'd1) ? 47 : 53;
        end
      end else begin
        if (m_cnt == 1) begin
          m_busy <= 1'b0;
          m_done <= 1'b1;
          m_kv   <= 1'b1;
          m_nr   <= (m_len_p == 2'd0) ? 4'd10 : (m_len_p == 2'd1) ? 4'd12 : 4'd14;
          m_key  <= m_key_p;
          m_len  <= m_len_p;
        end
        m_cnt <= m_cnt - 1;
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      check("ctrl {busy,done,err,key_valid,nr}", {busy, done, err, key_valid, nr},
            {m_busy, m_done, m_err, m_kv, m_nr});
      check($sformatf("rk_out idx %0d", rk_idx), rk_out,
            (m_kv && rk_idx <= m_nr) ? mround(m_key, m_len, rk_idx) : 128'h0);
    end
  end

  initial begin
    sweep = 4'd0;
    forever begin
      @(posedge clk);
      #2 sweep = sweep + 4'd3;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic chk_rk(input string name, input logic [3:0] idx, input logic [127:0] exp);
    hold_idx = idx;
    hold     = 1'b1;
    #1 check(name, rk_out, exp);
    hold     = 1'b0;
  endtask

  // Called at posedge+1 when quick, otherwise anywhere; returns at posedge+1 of done.
  task automatic run(input logic [255:0] key, input logic [1:0] len, input bit quick,
                     input bit repulse, output int lat);
    if (!quick) begin
      @(posedge clk);
      #2;
    end else begin
      #1;
    end
    start = 1'b1; key_in = key; key_len = len;
    @(posedge clk);
    #1;
    check("busy after accept", busy, 1'b1);
    check("key_valid cleared on accept", key_valid, 1'b0);
    #1;
    start = 1'b0; key_in = {8{$urandom}}; key_len = 2'($urandom_range(0, 3));
    lat = 0;
    while (!done && lat < 100) begin
      @(posedge clk);
      lat++;
      #1;
      if (repulse && lat == 10) begin
        #1 start = 1'b1; key_len = 2'b11; key_in = ~key;
      end else if (repulse && lat == 11) begin
        #1 start = 1'b0;
      end
    end
  endtask

  initial begin
    int lat;
    rst = 1'b1; start = 1'b0; key_len = 2'd0; key_in = '0;
    start1 = 1'b0; key_len1 = 2'd0; rk_idx1 = 4'd0; hold = 1'b0; hold_idx = 4'd0;
    for (int a = 0; a < 256; a++) sb[a] = sbox_math(8'(a));

    check("model sbox 00", {120'h0, sb[8'h00]}, 128'h63);
    check("model sbox 53", {120'h0, sb[8'h53]}, 128'hed);
    check("model 128 rk10", mround(K128, 2'd0, 4'd10), R128_10);
    check("model 192 rk12", mround(K192, 2'd1, 4'd12), R192_12);
    check("model 256 rk14", mround(K256, 2'd2, 4'd14), R256_14);

    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    #1 check("reset ctrl", {busy, done, err, key_valid, nr}, 128'h0);
    chk_rk("reset rk_out", 4'd0, 128'h0);

    // AES-128
    run(K128, 2'd0, 1'b0, 1'b0, lat);
    check("latency 128", lat, 41);
    chk_rk("128 rk10", 4'd10, R128_10);
    chk_rk("128 rk0", 4'd0, K128[255:128]);
    chk_rk("128 rk11 beyond nr", 4'd11, 128'h0);
    check("128 nr", nr, 4'd10);

    // AES-192
    run(K192, 2'd1, 1'b0, 1'b0, lat);
    check("latency 192", lat, 47);
    chk_rk("192 rk12", 4'd12, R192_12);
    check("192 nr", nr, 4'd12);

    // AES-256
    run(K256, 2'd2, 1'b0, 1'b0, lat);
    check("latency 256", lat, 53);
    chk_rk("256 rk14", 4'd14, R256_14);
    chk_rk("256 rk1", 4'd1, K256[127:0]);

    // Reserved key length: err only, schedule kept
    @(posedge clk);
    #2 start = 1'b1; key_len = 2'b11; key_in = K128;
    @(posedge clk);
    #1 check("err on reserved len", err, 1'b1);
    check("busy stays low on reject", busy, 1'b0);
    check("key_valid kept on reject", key_valid, 1'b1);
    chk_rk("rk14 kept on reject", 4'd14, R256_14);
    start = 1'b0;
    @(posedge clk);
    #1 check("err is one pulse", err, 1'b0);

    // Reset in the middle of an AES-256 expansion
    @(posedge clk);
    #2 start = 1'b1; key_len = 2'd2; key_in = K256;
    @(posedge clk);
    #2 start = 1'b0;
    repeat (19) @(posedge clk);
    #2 rst = 1'b1;
    #1 check("busy cleared by reset", busy, 1'b0);
    check("key_valid cleared by reset", key_valid, 1'b0);
    chk_rk("rk_out cleared by reset", 4'd0, 128'h0);
    @(posedge clk);
    #2 rst = 1'b0;
    run(K128, 2'd0, 1'b0, 1'b0, lat);
    check("latency 128 after reset", lat, 41);
    chk_rk("128 rk10 after reset", 4'd10, R128_10);

    // start re-pulsed while busy, then back-to-back 128 -> 256
    run(K128, 2'd0, 1'b0, 1'b1, lat);
    check("latency 128 with re-pulse", lat, 41);
    run(K256, 2'd2, 1'b1, 1'b0, lat);
    check("latency 256 back-to-back", lat, 53);
    chk_rk("b2b 256 rk14", 4'd14, R256_14);

    // Registered read port and disabled AES-256 on the second instance
    @(posedge clk);
    #2 start1 = 1'b1; key_len1 = 2'd0;
    key_in = K128;
    @(posedge clk);
    #2 start1 = 1'b0;
    lat = 0;
    while (!done1 && lat < 100) begin
      @(posedge clk);
      lat++;
      #1;
    end
    check("dut1 latency 128", lat, 41);
    #1 rk_idx1 = 4'd10;
    #1 check("dut1 rk_out not yet updated", rk_out1, 128'h0);
    @(posedge clk);
    #1 check("dut1 rk10 registered", rk_out1, R128_10);
    #1 start1 = 1'b1; key_len1 = 2'd2; key_in = K256;
    @(posedge clk);
    #1 check("dut1 err on disabled 256", err1, 1'b1);
    check("dut1 busy stays low", busy1, 1'b0);
    check("dut1 key_valid kept", key_valid1, 1'b1);
    check("dut1 rk10 kept", rk_out1, R128_10);
    #1 start1 = 1'b0;
    @(posedge clk);
    #1 check("dut1 err is one pulse", err1, 1'b0);
    check("dut1 nr", nr1, 4'd10);

    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
